pong_sync_gen: RTL
==================

Name: pong_sync_gen

Overview:
- Synchronous horizontal/vertical timing generator for the discrete-logic Pong core.
- Replaces the ripple 7493/74107 counter chains and their gate-level reset/blank/sync decodes with one clocked block.
- Sits directly upstream of the gate-level combinational models (NOR/NAND decode, video summing, net/paddle windows), which consume its counts and sync/blank flags.

Parameters:
- H_TOTAL, 455: horizontal counts per line.
- V_TOTAL, 262: lines per frame.
- H_BLANK_END, 80: first visible hcount; hblank is active for hcount 0..H_BLANK_END-1.
- H_SYNC_START, 32: first hcount with hsync_n low.
- H_SYNC_END, 64: first hcount after hsync_n low ends.
- V_BLANK_END, 16: first visible vcount.
- V_SYNC_START, 4: first vcount with vsync_n low.
- V_SYNC_END, 8: first vcount after vsync_n low ends.

Ports:
- clk  in  1  core clock (7.159 MHz domain)
- rst_n  in  1  synchronous active-low reset
- hcount  out  9  horizontal count (bit n = "2^n H")
- vcount  out  9  vertical count (bit n = "2^n V")
- hreset  out  1  high for the single cycle where hcount == H_TOTAL-1
- vreset  out  1  high for the single cycle where hreset is high and vcount == V_TOTAL-1
- hblank  out  1  horizontal blank, active high
- vblank  out  1  vertical blank, active high
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- Clocking: one clock; reset is synchronous and active-low.

Behaviour:
- Advance = every rising clk edge, or only edges with ce high when PONG_SYNC_CE_EN is defined.
- On advance:
  - hcount = (hcount == H_TOTAL-1) ? 0 : hcount+1.
  - When hcount wraps: vcount = (vcount == V_TOTAL-1) ? 0 : vcount+1. Otherwise vcount holds.
- hblank, vblank, hsync_n and vsync_n are registered.
  - Each is computed from the next count value, so it changes in the same cycle the count does (zero latency relative to hcount/vcount).
  - hblank = next_h < H_BLANK_END.
  - hsync_n = !(H_SYNC_START <= next_h < H_SYNC_END).
  - vblank = next_v < V_BLANK_END.
  - vsync_n = !(V_SYNC_START <= next_v < V_SYNC_END).
- hreset and vreset are combinational decodes of the current counts; they feed the downstream gate models as line/frame strobes.
- Reset (rst_n low at a clk edge, with or without ce), regardless of state including mid-line or mid-sync:
  - hcount = 0, vcount = 0.
  - hblank = 1, vblank = 1, hsync_n = 1, vsync_n = 1.
  - hreset and vreset therefore read 0.
- Reset has priority over advance.
- Simultaneous hcount wrap and vcount wrap in one advance: both go to 0 in the same cycle; vreset and hreset are both high the cycle before.
- No advance: all registers hold and strobes stay at their decoded value.
- Width rule: counts are 9 bits. H_TOTAL and V_TOTAL must be <= 512, and sync/blank boundaries must satisfy START < END <= BLANK_END < TOTAL. Violations are flagged by an elaboration-time check (generate-time $error).

Optional Feature:
- Macro: PONG_SYNC_CE_EN.
- Defined: adds port ce (in, 1) after rst_n. Counters and registered flags advance only when ce is high, so the core can run from a faster MiST system clock with a 7.159 MHz enable.
- Undefined: no ce port; advance on every clk edge.

Decomposition:
- Shared package pong_timing_pkg holds:
  - default constants H_TOTAL_DEF = 455 and V_TOTAL_DEF = 262,
  - the blank/sync boundary constants,
  - a 9-bit count typedef used by downstream video/paddle blocks.
- One natural sub-module: pong_mod_counter (parameterised modulus, inc enable, wrap strobe), instantiated twice. The V instance's inc = advance & h_wrap.

Test Plan:
- Reset release: hold rst_n low 3 cycles, then release. Expect hcount=0, vcount=0, hblank=1, vblank=1, hsync_n=1, vsync_n=1. First advance gives hcount=1.
- Line wrap: run to hcount=454.
  - Expect hreset=1 for that single cycle.
  - Next cycle: hcount=0, vcount incremented, hblank=1.
  - At hcount=80: hblank=0.
  - hsync_n low exactly for hcount 32..63 (32 cycles).
- Frame wrap: run 262*455 cycles from reset.
  - vreset high only at (h=454, v=261); then h=0, v=0.
  - vsync_n low for vcount 4..7.
  - vblank high for vcount 0..15.
- Mid-sync reset: assert rst_n low at hcount=40, vcount=5 (both syncs low). The next edge gives counts 0 and hsync_n=vsync_n=1, with no glitch on the hreset/vreset decode.
- CE gating (PONG_SYNC_CE_EN): drive ce high 1 cycle in 4.
  - hcount advances once per 4 clocks; full line = 1820 clocks.
  - Reset asserted with ce low still clears all outputs.
- Parameter override: H_TOTAL=16, V_TOTAL=4, H_SYNC 2..4, H_BLANK_END 6, V_SYNC 1..2, V_BLANK_END 3.
  - hcount cycles 0..15.
  - Frame = 64 cycles.
  - All flags track the overridden boundaries.

Source files
------------

// File: rtl/pong_timing_pkg.sv
// Shared timing constants and count type for the Pong video path.
// Holds the default line/frame totals and the blank/sync boundaries used by
// pong_sync_gen. It also holds the 9-bit count type that the downstream
// video, net and paddle blocks consume.
package pong_timing_pkg;

  localparam int unsigned CountW = 9;
  typedef logic [CountW-1:0] count_t;

  localparam int unsigned H_TOTAL_DEF      = 455;
  localparam int unsigned V_TOTAL_DEF      = 262;
  localparam int unsigned H_BLANK_END_DEF  = 80;
  localparam int unsigned H_SYNC_START_DEF = 32;
  localparam int unsigned H_SYNC_END_DEF   = 64;
  localparam int unsigned V_BLANK_END_DEF  = 16;
  localparam int unsigned V_SYNC_START_DEF = 4;
  localparam int unsigned V_SYNC_END_DEF   = 8;

  // True when lo <= c < hi.
  function automatic logic in_window(input count_t c, input count_t lo, input count_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/pong_sync_gen_if.sv
// Timing bundle produced by pong_sync_gen.
// Signals:
//   hcount/vcount   current horizontal/vertical counts (bit n = "2^n H/V")
//   hreset/vreset   line/frame end strobes (combinational decode of counts)
//   hblank/vblank   active-high blanking
//   hsync_n/vsync_n active-low sync
// The master modport drives the bundle; the slave modport is for consumers.
interface pong_sync_gen_if;
  import pong_timing_pkg::*;

  count_t hcount;
  count_t vcount;
  logic   hreset;
  logic   vreset;
  logic   hblank;
  logic   vblank;
  logic   hsync_n;
  logic   vsync_n;

  modport master (
    output hcount, vcount, hreset, vreset, hblank, vblank, hsync_n, vsync_n
  );

  modport slave (
    input hcount, vcount, hreset, vreset, hblank, vblank, hsync_n, vsync_n
  );

endinterface

// File: rtl/pong_mod_counter.sv
// Modulus-N up counter with increment enable and wrap decode.
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset (count -> 0)
//   inc_i    advance the count this edge
//   count_o  current count
//   next_o   value the count takes at the next edge, ignoring reset
//   wrap_o   high while count == Modulus-1
module pong_mod_counter
  import pong_timing_pkg::*;
#(
  parameter int unsigned Modulus = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc_i,
  output count_t count_o,
  output count_t next_o,
  output logic   wrap_o
);

  localparam count_t Last = count_t'(Modulus - 1);

  count_t count_q, count_d;

  always_comb begin
    wrap_o  = (count_q == Last);
    count_d = count_q;
    if (inc_i) begin
      count_d = wrap_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/pong_sync_gen.sv
// Horizontal/vertical timing generator for the Pong core.
// Replaces the ripple counter chains and their gate-level decodes with one
// clocked block.
// Ports:
//   clk    core clock
//   rst_n  synchronous active-low reset
//   ce     advance enable (only when PONG_SYNC_CE_EN is defined)
//   tim    timing bundle (pong_sync_gen_if.master): counts, line/frame
//          strobes, blank and sync flags
// Optional feature macro: PONG_SYNC_CE_EN. When defined, it adds the ce port
// and advances only on edges where ce is high. When undefined, the block
// advances on every clock edge.
module pong_sync_gen
  import pong_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL      = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL      = V_TOTAL_DEF,
  parameter int unsigned H_BLANK_END  = H_BLANK_END_DEF,
  parameter int unsigned H_SYNC_START = H_SYNC_START_DEF,
  parameter int unsigned H_SYNC_END   = H_SYNC_END_DEF,
  parameter int unsigned V_BLANK_END  = V_BLANK_END_DEF,
  parameter int unsigned V_SYNC_START = V_SYNC_START_DEF,
  parameter int unsigned V_SYNC_END   = V_SYNC_END_DEF
) (
  input logic             clk,
  input logic             rst_n,
`ifdef PONG_SYNC_CE_EN
  input logic             ce,
`endif
  pong_sync_gen_if.master tim
);

  if (H_TOTAL > 512 || V_TOTAL > 512 ||
      !(H_SYNC_START < H_SYNC_END) || !(H_SYNC_END <= H_BLANK_END) ||
      !(H_BLANK_END < H_TOTAL) ||
      !(V_SYNC_START < V_SYNC_END) || !(V_SYNC_END <= V_BLANK_END) ||
      !(V_BLANK_END < V_TOTAL)) begin : g_bad_params
    $error("pong_sync_gen: illegal timing parameters");
  end

  localparam count_t HBlankEnd  = count_t'(H_BLANK_END);
  localparam count_t HSyncStart = count_t'(H_SYNC_START);
  localparam count_t HSyncEnd   = count_t'(H_SYNC_END);
  localparam count_t VBlankEnd  = count_t'(V_BLANK_END);
  localparam count_t VSyncStart = count_t'(V_SYNC_START);
  localparam count_t VSyncEnd   = count_t'(V_SYNC_END);

  logic advance;
`ifdef PONG_SYNC_CE_EN
  assign advance = ce;
`else
  assign advance = 1'b1;
`endif

  count_t h_count, h_next, v_count, v_next;
  logic   h_wrap, v_wrap;

  pong_mod_counter #(
    .Modulus (H_TOTAL)
  ) u_hcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (advance),
    .count_o (h_count),
    .next_o  (h_next),
    .wrap_o  (h_wrap)
  );

  pong_mod_counter #(
    .Modulus (V_TOTAL)
  ) u_vcnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (advance & h_wrap),
    .count_o (v_count),
    .next_o  (v_next),
    .wrap_o  (v_wrap)
  );

  // Flags are decoded from the next count so they change on the same edge
  // as the count they describe.
  logic hblank_q, hblank_d, vblank_q, vblank_d;
  logic hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;

  always_comb begin
    hblank_d  = hblank_q;
    vblank_d  = vblank_q;
    hsync_n_d = hsync_n_q;
    vsync_n_d = vsync_n_q;
    if (advance) begin
      hblank_d  = (h_next < HBlankEnd);
      hsync_n_d = !in_window(h_next, HSyncStart, HSyncEnd);
      vblank_d  = (v_next < VBlankEnd);
      vsync_n_d = !in_window(v_next, VSyncStart, VSyncEnd);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b1;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
    end else begin
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
    end
  end

  assign tim.hcount  = h_count;
  assign tim.vcount  = v_count;
  assign tim.hreset  = h_wrap;
  assign tim.vreset  = h_wrap & v_wrap;
  assign tim.hblank  = hblank_q;
  assign tim.vblank  = vblank_q;
  assign tim.hsync_n = hsync_n_q;
  assign tim.vsync_n = vsync_n_q;

endmodule
